// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester-side access port of the memory arbiter
interface mem_port_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 16
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/loader arbiter for the single-port instruction/data memory
module mem_port_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 16,
   parameter int MAX_HOLD = 4
) (
   input  logic          CLK,
   input  logic          reset,
   mem_port_arbiter_if.slave cpu,
   mem_port_arbiter_if.slave ldr,
   input  logic          ldr_lock,
   output logic          cpu_stall,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LDR = 1'b1
   } owner_t;

   owner_t        last, last_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic          gnt_cpu, gnt_ldr;
   logic          tag_valid;
   owner_t        tag_owner;
   logic          cpu_rvalid_q, ldr_rvalid_q;

   // A locked loader keeps winning ties only while it already owns the port
   // and has not yet used up its MAX_HOLD budget.
   always_comb begin
      gnt_cpu  = 1'b0;
      gnt_ldr  = 1'b0;
      last_nxt = last;
      hold_nxt = '0;
      if (reset) begin
         if (cpu.req && ldr.req) begin
            if (ldr_lock && last == OWN_LDR && hold_cnt < HOLD_MAX)
               gnt_ldr = 1'b1;
            else if (last == OWN_LDR)
               gnt_cpu = 1'b1;
            else
               gnt_ldr = 1'b1;
         end else begin
            gnt_cpu = cpu.req;
            gnt_ldr = ldr.req;
         end
      end
      if (gnt_cpu)
         last_nxt = OWN_CPU;
      if (gnt_ldr) begin
         last_nxt = OWN_LDR;
         hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         last         <= OWN_LDR;
         hold_cnt     <= '0;
         mem_re       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         tag_valid    <= 1'b0;
         tag_owner    <= OWN_CPU;
         cpu_rvalid_q <= 1'b0;
         ldr_rvalid_q <= 1'b0;
      end else begin
         last         <= last_nxt;
         hold_cnt     <= hold_nxt;
         cpu_rvalid_q <= tag_valid && tag_owner == OWN_CPU;
         ldr_rvalid_q <= tag_valid && tag_owner == OWN_LDR;
         if (gnt_cpu) begin
            mem_re    <= ~cpu.we;
            mem_we    <= cpu.we;
            mem_addr  <= cpu.addr;
            mem_wdata <= cpu.wdata;
            tag_valid <= ~cpu.we;
            tag_owner <= OWN_CPU;
         end else if (gnt_ldr) begin
            mem_re    <= ~ldr.we;
            mem_we    <= ldr.we;
            mem_addr  <= ldr.addr;
            mem_wdata <= ldr.wdata;
            tag_valid <= ~ldr.we;
            tag_owner <= OWN_LDR;
         end else begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            tag_valid <= 1'b0;
         end
      end
   end

   assign cpu.gnt    = gnt_cpu;
   assign ldr.gnt    = gnt_ldr;
   assign cpu.rvalid = cpu_rvalid_q;
   assign ldr.rvalid = ldr_rvalid_q;
   assign cpu.rdata  = mem_rdata;
   assign ldr.rdata  = mem_rdata;
   assign cpu_stall  = reset & cpu.req & ~gnt_cpu;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int MAX_HOLD = 4;

   logic          CLK = 1'b0;
   logic          reset = 1'b0;
   logic          ldr_lock = 1'b0;
   logic          cpu_stall;
   logic          mem_re, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) cpu_if ();
   mem_port_arbiter_if #(.AW(AW), .DW(DW)) ldr_if ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
      .CLK(CLK), .reset(reset), .cpu(cpu_if.slave), .ldr(ldr_if.slave),
      .ldr_lock(ldr_lock), .cpu_stall(cpu_stall), .mem_re(mem_re), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 CLK = ~CLK;

   // Synchronous single-port memory behind the arbiter
   logic [DW-1:0] ram [256];
   logic [DW-1:0] ref_ram [256];
   always @(posedge CLK) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: who owned the port last, how long the loader has held it,
   // what the memory port should show, and the read still waiting to return.
   bit            m_last_ldr = 1'b1;
   int            m_streak = 0;
   bit            e_re = 0, e_we = 0, e_crv = 0, e_lrv = 0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wdata = '0, e_rdata = '0;
   bit            p_valid = 0, p_ldr = 0;
   logic [DW-1:0] p_data = '0;
   int            cpu_wait = 0;

   // win: 0 none, 1 CPU, 2 loader
   task automatic step(input bit rst, input bit cr, input bit cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input bit lr, input bit lw,
                       input logic [AW-1:0] la, input logic [DW-1:0] ld, input bit lk,
                       output int win_obs, output bit crv_obs, output logic [DW-1:0] crd_obs);
      int win;
      bit we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      @(negedge CLK);
      check("mem_re", mem_re, e_re);
      check("mem_we", mem_we, e_we);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("cpu_rvalid", cpu_if.rvalid, e_crv);
      check("ldr_rvalid", ldr_if.rvalid, e_lrv);
      if (e_crv) check("cpu_rdata", cpu_if.rdata, e_rdata);
      if (e_lrv) check("ldr_rdata", ldr_if.rdata, e_rdata);
      crv_obs = cpu_if.rvalid;
      crd_obs = cpu_if.rdata;

      reset = rst; ldr_lock = lk;
      cpu_if.req = cr; cpu_if.we = cw; cpu_if.addr = ca; cpu_if.wdata = cd;
      ldr_if.req = lr; ldr_if.we = lw; ldr_if.addr = la; ldr_if.wdata = ld;
      #1;
      if (!rst) win = 0;
      else if (cr && !lr) win = 1;
      else if (lr && !cr) win = 2;
      else if (!cr && !lr) win = 0;
      else if (lk && m_last_ldr && m_streak < MAX_HOLD) win = 2;
      else win = m_last_ldr ? 1 : 2;
      check("cpu_gnt", cpu_if.gnt, win == 1);
      check("ldr_gnt", ldr_if.gnt, win == 2);
      check("cpu_stall", cpu_stall, rst && cr && win != 1);
      win_obs = cpu_if.gnt ? 1 : (ldr_if.gnt ? 2 : 0);
      if (rst && cr && !cpu_if.gnt) cpu_wait++;
      else cpu_wait = 0;
      check("cpu_starve", cpu_wait <= MAX_HOLD, 1);

      @(posedge CLK);
      if (!rst) begin
         e_re = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_crv = 0; e_lrv = 0;
         p_valid = 0; m_last_ldr = 1; m_streak = 0;
      end else begin
         e_crv = p_valid && !p_ldr;
         e_lrv = p_valid && p_ldr;
         e_rdata = p_data;
         if (win == 0) begin
            e_re = 0; e_we = 0; p_valid = 0; m_streak = 0;
         end else begin
            we = (win == 1) ? cw : lw;
            a  = (win == 1) ? ca : la;
            d  = (win == 1) ? cd : ld;
            e_re = !we; e_we = we; e_addr = a; e_wdata = d;
            if (we) ref_ram[a] = d;
            else p_data = ref_ram[a];
            p_valid = !we;
            p_ldr = (win == 2);
            m_last_ldr = (win == 2);
            m_streak = (win == 2) ? ((m_streak < MAX_HOLD) ? m_streak + 1 : MAX_HOLD) : 0;
         end
      end
   endtask

   int            w;
   bit            crv;
   logic [DW-1:0] crd;
   int            exp_alt [6] = '{1, 2, 1, 2, 1, 2};
   int            exp_lock [4] = '{2, 2, 2, 1};

   bit            rcr, rcw, rlr, rlw;
   logic [AW-1:0] rca, rla;
   logic [DW-1:0] rcd, rld;
   bit            rrst, rlk;

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i] = DW'($urandom);
         ref_ram[i] = ram[i];
      end
      ram[8'h12] = 16'hBEEF;
      ref_ram[8'h12] = 16'hBEEF;
      cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = '0; cpu_if.wdata = '0;
      ldr_if.req = 0; ldr_if.we = 0; ldr_if.addr = '0; ldr_if.wdata = '0;

      // Reset held with both requesters asking
      for (int i = 0; i < 2; i++)
         step(0, 1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0, 1, w, crv, crd);

      // Contention without lock alternates, CPU first
      for (int i = 0; i < 6; i++) begin
         step(1, 1, 0, 8'h10, 16'h0, 1, 0, 8'h20, 16'h0, 0, w, crv, crd);
         check("alt_order", w, exp_alt[i]);
      end

      // Locked burst after the loader's last grant
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 0, 8'h11, 16'h0, 1, 0, 8'h21, 16'h0, 1, w, crv, crd);
         check("lock_order", w, exp_lock[i]);
      end

      // CPU read alone
      step(1, 1, 0, 8'h12, 16'h0, 0, 0, 8'h0, 16'h0, 0, w, crv, crd);
      step(1, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 0, w, crv, crd);
      step(1, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 0, w, crv, crd);
      check("cpu_read_valid", crv, 1);
      check("cpu_read_beef", crd, 16'hBEEF);

      // Loader write then CPU read of the same address
      step(1, 0, 0, 8'h0, 16'h0, 1, 1, 8'h40, 16'h1234, 0, w, crv, crd);
      step(1, 1, 0, 8'h40, 16'h0, 0, 0, 8'h0, 16'h0, 0, w, crv, crd);
      step(1, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 0, w, crv, crd);
      step(1, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 0, w, crv, crd);
      check("wr_rd_valid", crv, 1);
      check("wr_rd_data", crd, 16'h1234);

      // Reset right after a CPU read grant drops the read
      step(1, 1, 0, 8'h12, 16'h0, 0, 0, 8'h0, 16'h0, 0, w, crv, crd);
      step(0, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 0, w, crv, crd);
      step(1, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 0, w, crv, crd);
      check("rst_drop_a", crv, 0);
      step(1, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 0, w, crv, crd);
      check("rst_drop_b", crv, 0);

      // Randomized traffic; a pending request keeps its command until granted
      rcr = 0; rlr = 0; w = 0;
      for (int i = 0; i < 3000; i++) begin
         rrst = ($urandom_range(0, 63) != 0);
         rlk  = ($urandom_range(0, 3) != 0);
         if (!(rcr && w != 1)) begin
            rcr = ($urandom_range(0, 3) != 0);
            rcw = $urandom_range(0, 1) == 1;
            rca = AW'($urandom_range(0, 15));
            rcd = DW'($urandom);
         end
         if (!(rlr && w != 2)) begin
            rlr = ($urandom_range(0, 3) != 0);
            rlw = $urandom_range(0, 1) == 1;
            rla = AW'($urandom_range(0, 15));
            rld = DW'($urandom);
         end
         step(rrst, rcr, rcw, rca, rcd, rlr, rlw, rla, rld, rlk, w, crv, crd);
      end

      step(1, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 0, w, crv, crd);
      step(1, 0, 0, 8'h0, 16'h0, 0, 0, 8'h0, 16'h0, 0, w, crv, crd);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the CPU's single-port instruction/data memory. It shares the memory between the CPU control path (fetch, LDW, STW accesses) and a loader/debug port that writes programs into memory and reads results back. The block arbitrates per cycle and registers the winning command onto the memory port. It routes read data back to the correct requester and raises a stall to the CPU while the CPU's request is not being served.

## Interface
- AW, 8, address width
- DW, 16, data width
- MAX_HOLD, 4, max consecutive locked loader grants before a waiting CPU request must win (≥1)

- CLK  in  1  clock
- reset  in  1  synchronous, active-low
- cpu_req  in  1  CPU access request; hold with cmd stable until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  request accepted at this rising edge (combinational)
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  cpu_rdata valid this cycle
- cpu_rdata  out  DW  read data (= mem_rdata)
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata  same as cpu_* for loader
- ldr_lock  in  1  loader requests burst priority
- mem_re  out  1  registered read strobe
- mem_we  out  1  registered write strobe
- mem_addr  out  AW  registered address
- mem_wdata  out  DW  registered write data
- mem_rdata  in  DW  synchronous memory output, valid cycle after mem_re

## Operation
- State: last (owner of most recent grant, CPU/LDR), hold_cnt (0..MAX_HOLD), rd_tag pipeline (valid + owner, one stage).
- Grant decision, evaluated combinationally each cycle; at most one gnt high:
  - reset low: no grant.
  - only one req high: grant it.
  - both high, ldr_lock=1, last=LDR, hold_cnt<MAX_HOLD: grant LDR.
  - both high otherwise: grant requester ≠ last (round-robin).
- On grant edge: mem_re=~we, mem_we=we, mem_addr/mem_wdata from winner; last←winner; rd_tag←(read, winner).
- No grant: mem_re=mem_we=0; mem_addr/mem_wdata hold previous values.
- hold_cnt: +1 (saturating at MAX_HOLD) on each LDR grant; cleared on any cycle without an LDR grant.
- Read return: rvalid of tagged owner is asserted one cycle after mem_re. rdata is passed to both ports; consumers qualify it by rvalid.
- Requester holding req high after the gnt edge issues a new access; back-to-back grants to the same or alternate requesters every cycle are allowed.
- Writes: no response pulse; accepted at gnt edge, performed in the mem_we cycle.

## Timing
- Request accepted at edge E (gnt high in cycle before E). mem_re/mem_we high cycle E+1. rvalid high cycle E+2. Read latency is 2 cycles from acceptance.
- Throughput: 1 access/cycle total.
- Reset (reset=0 at edge) values: mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rvalid=ldr_rvalid=0, last=LDR (CPU wins first tie), hold_cnt=0, rd_tag invalid.
- While reset is low, cpu_gnt, ldr_gnt and cpu_stall are 0.
- Reset mid-operation: in-flight reads are dropped, with no rvalid after the reset edge. An issued mem_we cycle already present is not retracted.
- Simultaneous read return and new grant are independent; they pipeline cleanly.
- ldr_lock with last=CPU does not preempt; round-robin applies for that cycle.
- Starvation bound: a held cpu_req waits at most MAX_HOLD cycles.

## Test plan
- Reset: hold reset=0 for 2 cycles with both reqs high. Required: no gnt, mem_re=mem_we=0, rvalid=0, all reset values as listed.
- CPU read alone: cpu_req, addr 0x12, memory holds 0xBEEF. Required: cpu_gnt same cycle, mem_re+mem_addr=0x12 next cycle, cpu_rvalid with cpu_rdata=0xBEEF 2 cycles after acceptance, no ldr_rvalid.
- Contention, no lock: both reqs held 6 cycles. Required: grants alternate CPU,LDR,CPU,LDR,CPU,LDR; cpu_stall high exactly on LDR-grant cycles.
- Locked burst, MAX_HOLD=4: ldr_lock=1, LDR last granted, both reqs held. Required: LDR gets 4 consecutive grants, then CPU granted; hold_cnt returns to 0.
- Loader write then CPU read of same addr: ldr write 0x0040←0x1234, then cpu read 0x0040. Required: mem_we cycle precedes mem_re; cpu_rdata=0x1234.
- Reset mid-read: assert reset=0 on the edge after a CPU read grant. Required: no cpu_rvalid thereafter; outputs at reset values next cycle.
